// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared encodings for the GCD controller and the subtraction datapath.
//   - compare codes returned by the datapath (CMP_*)
//   - edit_num codes driven to the datapath (EDIT_*)
//   - controller FSM state encoding (state_t)
package gcd_pkg;

  localparam logic [1:0] CMP_NONE = 2'd0;  // no result yet, or an operand is zero
  localparam logic [1:0] CMP_EQ   = 2'd1;  // a == b
  localparam logic [1:0] CMP_AGT  = 2'd2;  // a >  b
  localparam logic [1:0] CMP_BGT  = 2'd3;  // a <  b

  localparam logic [1:0] EDIT_NONE = 2'd0;  // hold operands
  localparam logic [1:0] EDIT_A    = 2'd1;  // a <= a - b
  localparam logic [1:0] EDIT_B    = 2'd2;  // b <= b - a

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    EVAL    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/gcd_controller.sv
// gcd_controller
// Control FSM for the subtraction-based GCD datapath. A job is accepted on
// req while idle, the operands are loaded into the datapath, one subtract is
// issued per valid compare result, and the final datapath output is
// registered as the result. A step counter aborts runaway jobs at MAX_ITER.
//
// Ports
//   clk, rst_n          clock and synchronous active-low reset
//   req, op_a, op_b     job request and operands (sampled only in IDLE)
//   busy, done          busy from LOAD through DONE; done is a 1-cycle pulse
//   result, err, steps  job outcome, held until the next acceptance
//   dp_a, dp_b          registered operands toward the datapath
//   dp_start, edit_num, get_res   datapath controls (decoded from state)
//   compare, dp_out     registered datapath status and output
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int MAX_ITER = 1023,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_start,
  output logic [1:0]       edit_num,
  output logic             get_res,
  input  logic [1:0]       compare,
  input  logic [WIDTH-1:0] dp_out
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_t state_q;
  state_t state_d;

  logic subtract;   // compare says the operands still differ
  logic at_limit;   // step budget exhausted

  assign subtract = (compare == CMP_AGT) || (compare == CMP_BGT);
  assign at_limit = (steps == MAX_CNT);

  // State register plus the job registers written on specific transitions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      result  <= '0;
      err     <= 1'b0;
      steps   <= '0;
      dp_a    <= '0;
      dp_b    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            dp_a  <= op_a;
            dp_b  <= op_b;
            steps <= '0;
            err   <= 1'b0;
          end
        end
        EVAL: begin
          // The limit is tested before incrementing, so steps never wraps.
          if (subtract) begin
            if (at_limit) begin
              err <= 1'b1;
            end else begin
              steps <= steps + 1'b1;
            end
          end
        end
        CAPTURE: begin
          // An aborted job also passes through CAPTURE so that done always
          // lands at the same offset after the last subtract; its result is 0.
          result <= err ? '0 : dp_out;
        end
        default: ;
      endcase
    end
  end

  // Next state and datapath controls, decoded purely from state and compare.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    done     = 1'b0;
    dp_start = 1'b0;
    edit_num = EDIT_NONE;
    get_res  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (req) state_d = LOAD;
      end
      LOAD: begin
        dp_start = 1'b1;
        state_d  = SETTLE;
      end
      SETTLE: begin
        // compare still reflects the operands from before the last edit.
        state_d = EVAL;
      end
      EVAL: begin
        case (compare)
          CMP_EQ: begin
            get_res = 1'b1;
            state_d = CAPTURE;
          end
          CMP_NONE: begin
            // An operand is zero: dp_out already holds max(a, b).
            state_d = CAPTURE;
          end
          default: begin
            if (at_limit) begin
              state_d = CAPTURE;
            end else begin
              edit_num = (compare == CMP_AGT) ? EDIT_A : EDIT_B;
              state_d  = SETTLE;
            end
          end
        endcase
      end
      CAPTURE: begin
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller
// Drives two controllers (MAX_ITER=1023 and MAX_ITER=3), each attached to a
// small behavioural datapath with registered outputs, and compares every job
// against a plain-arithmetic GCD reference.
module tb_gcd_controller;

  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req[2];
  logic [W-1:0] op_a[2];
  logic [W-1:0] op_b[2];
  logic         busy[2];
  logic         done_s[2];
  logic [W-1:0] result[2];
  logic         err[2];
  logic [9:0]   steps[2];
  logic [W-1:0] dpa[2];
  logic [W-1:0] dpb[2];
  logic         dps[2];
  logic [1:0]   edit[2];
  logic         getr[2];
  logic [1:0]   cmp[2];
  logic [W-1:0] dout[2];

  // Behavioural datapath: operand registers plus registered compare/out.
  logic [W-1:0] ma[2];
  logic [W-1:0] mb[2];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dps[i]) begin
        ma[i] <= dpa[i];
        mb[i] <= dpb[i];
      end else if (edit[i] == 2'd1) begin
        ma[i] <= ma[i] - mb[i];
      end else if (edit[i] == 2'd2) begin
        mb[i] <= mb[i] - ma[i];
      end
      if (ma[i] == 0 || mb[i] == 0) cmp[i] <= 2'd0;
      else if (ma[i] == mb[i])      cmp[i] <= 2'd1;
      else if (ma[i] > mb[i])       cmp[i] <= 2'd2;
      else                          cmp[i] <= 2'd3;
      dout[i] <= (ma[i] > mb[i]) ? ma[i] : mb[i];
    end
  end

  gcd_controller #(.WIDTH(W), .MAX_ITER(1023), .CNT_W(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .op_a(op_a[0]), .op_b(op_b[0]),
    .busy(busy[0]), .done(done_s[0]), .result(result[0]), .err(err[0]),
    .steps(steps[0]), .dp_a(dpa[0]), .dp_b(dpb[0]), .dp_start(dps[0]),
    .edit_num(edit[0]), .get_res(getr[0]), .compare(cmp[0]), .dp_out(dout[0])
  );

  gcd_controller #(.WIDTH(W), .MAX_ITER(3), .CNT_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .op_a(op_a[1]), .op_b(op_b[1]),
    .busy(busy[1]), .done(done_s[1]), .result(result[1]), .err(err[1]),
    .steps(steps[1]), .dp_a(dpa[1]), .dp_b(dpb[1]), .dp_start(dps[1]),
    .edit_num(edit[1]), .get_res(getr[1]), .compare(cmp[1]), .dp_out(dout[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: Euclid by repeated subtraction with a step budget.
  function automatic void gcd_ref(input int a, input int b, input int maxit,
                                  output int res, output int n, output int e);
    n = 0; e = 0; res = 0;
    forever begin
      if (a == 0 || b == 0) begin res = (a > b) ? a : b; return; end
      if (a == b) begin res = a; return; end
      if (n == maxit) begin e = 1; res = 0; return; end
      if (a > b) a = a - b; else b = b - a;
      n++;
    end
  endfunction

  // Run one job on instance i. held_prev: req is still high from the
  // previous job and we are in its DONE cycle. keep_req: leave req high.
  // pulse_at: cycle in which to pulse a spurious req (0 = none).
  task automatic run_job(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit held_prev, input bit keep_req, input int pulse_at);
    int cyc, edits, nbusy, res, n, e, maxit;
    maxit = (i == 0) ? 1023 : 3;
    gcd_ref(int'(a), int'(b), maxit, res, n, e);
    op_a[i] = a;
    op_b[i] = b;
    if (held_prev) begin
      @(negedge clk);
      check("idle_gap_busy", 32'(busy[i]), 32'd0);
    end else begin
      @(negedge clk);
      req[i] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc = 1; edits = 0; nbusy = 0;
    if (!keep_req) req[i] = 1'b0;
    check("dp_a", 32'(dpa[i]), 32'(a));
    check("dp_b", 32'(dpb[i]), 32'(b));
    while (!done_s[i] && cyc < 2 * 1023 + 20) begin
      if (!busy[i]) nbusy++;
      if (edit[i] != 2'd0) edits++;
      if (pulse_at != 0 && cyc == pulse_at) begin
        req[i] = 1'b1; op_a[i] = 10'd5; op_b[i] = 10'd10;
      end else if (pulse_at != 0 && cyc == pulse_at + 1) begin
        req[i] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 32'(done_s[i]), 32'd1);
    check("busy_at_done", 32'(busy[i]), 32'd1);
    check("busy_gaps", 32'(nbusy), 32'd0);
    check("done_cycle", 32'(cyc), 32'(2 * n + 5));
    check("result", 32'(result[i]), 32'(res));
    check("err", 32'(err[i]), 32'(e));
    check("steps", 32'(steps[i]), 32'(n));
    check("edits", 32'(edits), 32'(n));
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; op_a[i] = '0; op_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done_s[0]), 32'd0);
    check("rst_result", 32'(result[0]), 32'd0);
    check("rst_steps", 32'(steps[0]), 32'd0);
    check("rst_dp_start", 32'(dps[0]), 32'd0);
    check("rst_edit", 32'(edit[0]), 32'd0);
    rst_n = 1'b1;

    run_job(0, 10'd12, 10'd18, 0, 0, 0);
    run_job(0, 10'd48, 10'd18, 0, 0, 0);
    run_job(0, 10'd7,  10'd7,  0, 0, 0);
    run_job(0, 10'd0,  10'd25, 0, 0, 0);
    run_job(0, 10'd0,  10'd0,  0, 0, 0);
    run_job(1, 10'd1000, 10'd1, 0, 0, 0);

    // Spurious req while busy must be ignored: exactly one done.
    run_job(0, 10'd12, 10'd18, 0, 0, 3);
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done_s[0]) nd++;
      if (busy[0]) nd++;
    end
    check("no_extra_job", 32'(nd), 32'd0);

    // Reset during SETTLE aborts the job without a done pulse.
    @(negedge clk);
    req[0] = 1'b1; op_a[0] = 10'd50; op_b[0] = 10'd20;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_done", 32'(done_s[0]), 32'd0);
    check("midrst_result", 32'(result[0]), 32'd0);
    check("midrst_steps", 32'(steps[0]), 32'd0);
    check("midrst_dp_a", 32'(dpa[0]), 32'd0);
    check("midrst_dp_b", 32'(dpb[0]), 32'd0);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done_s[0] || busy[0]) nd++;
    end
    check("midrst_quiet", 32'(nd), 32'd0);
    run_job(0, 10'd9, 10'd6, 0, 0, 0);

    // req held high across three back-to-back jobs.
    run_job(0, 10'd20,  10'd8,  0, 1, 0);
    run_job(0, 10'd35,  10'd21, 1, 1, 0);
    run_job(0, 10'd100, 10'd75, 1, 0, 0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      logic [W-1:0] ra, rb;
      if (j % 5 == 0) begin
        ra = W'($urandom_range(0, 1023));
        rb = W'($urandom_range(0, 1023));
      end else begin
        ra = W'($urandom_range(0, 300));
        rb = W'($urandom_range(0, 300));
      end
      run_job(0, ra, rb, 0, 0, 0);
    end
    for (int j = 0; j < 6; j++) begin
      run_job(1, W'($urandom_range(0, 1023)), W'($urandom_range(0, 60)), 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
